// File: rtl/time_glyph_renderer_if.sv
// Plot-side bundle between the timer display controller and the glyph
// renderer: render request, glyph snapshot inputs and VGA pixel outputs.
interface time_glyph_renderer_if;
    logic        start;
    logic [7:0]  originX;
    logic [6:0]  originY;
    logic [39:0] displayMin2;
    logic [39:0] displayMin1;
    logic [39:0] displayColon;
    logic [39:0] displaySec2;
    logic [39:0] displaySec1;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, originX, originY,
        output displayMin2, displayMin1, displayColon,
        output displaySec2, displaySec1,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, originX, originY,
        input  displayMin2, displayMin1, displayColon,
        input  displaySec2, displaySec1,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/time_glyph_renderer.sv
// Rasterises the five 5x8 MM:SS glyphs into the VGA plot port,
// one pixel per clock, lit and unlit pixels alike.
module time_glyph_renderer #(
    parameter int unsigned CHAR_PITCH = 6,
    parameter logic [2:0]  FG_COLOUR  = 3'b111,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input logic            clock,
    input logic            resetn,
    time_glyph_renderer_if.slave io
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

    state_e      state_q, state_d;
    logic [39:0] glyph_q [5];
    logic [39:0] glyph_d [5];
    logic [7:0]  ox_q, ox_d;
    logic [6:0]  oy_q, oy_d;
    logic [2:0]  ch_q, ch_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        last_q, last_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [39:0] cur_glyph;

    function automatic logic [7:0] pix_x(input logic [7:0] ox,
                                         input logic [2:0] ch,
                                         input logic [2:0] col);
        logic [7:0] off;
        off = 8'(32'(ch) * CHAR_PITCH);
        return ox + off + {5'd0, col};
    endfunction

    function automatic logic pix_bit(input logic [39:0] g,
                                     input logic [2:0]  row,
                                     input logic [2:0]  col);
        logic [5:0] idx;
        idx = {3'd0, row} * 6'd5 + {3'd0, col};
        return g[idx];
    endfunction

    always_comb begin
        cur_glyph = glyph_q[0];
        unique case (ch_q)
            3'd1:    cur_glyph = glyph_q[1];
            3'd2:    cur_glyph = glyph_q[2];
            3'd3:    cur_glyph = glyph_q[3];
            3'd4:    cur_glyph = glyph_q[4];
            default: cur_glyph = glyph_q[0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        glyph_d  = glyph_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        ch_d     = ch_q;
        row_d    = row_q;
        col_d    = col_q;
        last_d   = last_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Pixel 0 comes straight from the inputs so it lands one cycle after start.
                if (io.start) begin
                    state_d    = DRAW;
                    glyph_d[0] = io.displayMin2;
                    glyph_d[1] = io.displayMin1;
                    glyph_d[2] = io.displayColon;
                    glyph_d[3] = io.displaySec2;
                    glyph_d[4] = io.displaySec1;
                    ox_d       = io.originX;
                    oy_d       = io.originY;
                    x_d        = io.originX;
                    y_d        = io.originY;
                    colour_d   = io.displayMin2[0] ? FG_COLOUR : BG_COLOUR;
                    plot_d     = 1'b1;
                    busy_d     = 1'b1;
                    ch_d       = 3'd0;
                    row_d      = 3'd0;
                    col_d      = 3'd1;
                    last_d     = 1'b0;
                end
            end
            DRAW: begin
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ch_d    = 3'd0;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    last_d  = 1'b0;
                end else begin
                    x_d      = pix_x(ox_q, ch_q, col_q);
                    y_d      = oy_q + {4'd0, row_q};
                    colour_d = pix_bit(cur_glyph, row_q, col_q) ? FG_COLOUR : BG_COLOUR;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    last_d   = (ch_q == 3'd4) && (row_q == 3'd7) && (col_q == 3'd4);
                    if (col_q == 3'd4) begin
                        col_d = 3'd0;
                        if (row_q == 3'd7) begin
                            row_d = 3'd0;
                            ch_d  = ch_q + 3'd1;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            for (int i = 0; i < 5; i++) glyph_q[i] <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            ch_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            last_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= BG_COLOUR;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            glyph_q  <= glyph_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            ch_q     <= ch_d;
            row_q    <= row_d;
            col_q    <= col_d;
            last_q   <= last_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign io.x      = x_q;
    assign io.y      = y_q;
    assign io.colour = colour_q;
    assign io.plot   = plot_q;
    assign io.busy   = busy_q;
    assign io.done   = done_q;

endmodule

// File: tb/tb_time_glyph_renderer.sv
// Bench for time_glyph_renderer: pixel-table vectors, random frames
// against a scan-order model, and hand-written corner sequences.
module tb_time_glyph_renderer;

    localparam logic [39:0] ZERO  = 40'b0111010001100011000101110100011000101110;
    localparam logic [39:0] SEVEN = 40'b0001000010000100010000100010000100011111;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    time_glyph_renderer_if io();

    time_glyph_renderer dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (io)
    );

    int checks = 0;
    int errors = 0;

    // Frame parameters as presented at start.
    logic [7:0]  m_ox;
    logic [6:0]  m_oy;
    logic [39:0] m_g [5];

    // Captured frame.
    logic [7:0] cap_x [200];
    logic [6:0] cap_y [200];
    logic [2:0] cap_c [200];
    int plot_n, first_plot, last_plot, done_n, done_at, busy_bad;

    typedef struct {
        logic [7:0]  ox;
        logic [6:0]  oy;
        logic [39:0] g;
        logic [39:0] s1;
        int          idx;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: pixel i of the frame from plain scan-order arithmetic.
    task automatic model(input int i, output logic [7:0] ex,
                         output logic [6:0] ey, output logic [2:0] ec);
        int ch, b, r, c;
        logic [39:0] g;
        ch = i / 40;
        b  = i % 40;
        r  = b / 5;
        c  = b % 5;
        g  = m_g[ch];
        ex = 8'((int'(m_ox) + ch * 6 + c) % 256);
        ey = 7'((int'(m_oy) + r) % 128);
        ec = g[b] ? 3'b111 : 3'b000;
    endtask

    task automatic drive_inputs();
        io.originX      = m_ox;
        io.originY      = m_oy;
        io.displayMin2  = m_g[0];
        io.displayMin1  = m_g[1];
        io.displayColon = m_g[2];
        io.displaySec2  = m_g[3];
        io.displaySec1  = m_g[4];
    endtask

    task automatic run_frame(input int win, input bit mutate);
        @(negedge clock);
        drive_inputs();
        io.start = 1'b1;
        plot_n = 0; first_plot = -1; last_plot = -1;
        done_n = 0; done_at = -1; busy_bad = 0;
        for (int n = 1; n <= win; n++) begin
            @(negedge clock);
            if (n == 1) io.start = 1'b0;
            if (io.plot) begin
                if (plot_n < 200) begin
                    cap_x[plot_n] = io.x;
                    cap_y[plot_n] = io.y;
                    cap_c[plot_n] = io.colour;
                end
                if (plot_n == 0) first_plot = n;
                last_plot = n;
                plot_n++;
            end
            if (io.busy !== io.plot) busy_bad++;
            if (io.done) begin
                done_n++;
                done_at = n;
                if (io.plot || io.busy) busy_bad++;
            end
            if (mutate && n == 10) begin
                io.originX      = m_ox ^ 8'h5a;
                io.originY      = m_oy ^ 7'h33;
                io.displayMin2  = '1;
                io.displayMin1  = '1;
                io.displayColon = '1;
                io.displaySec2  = '1;
                io.displaySec1  = '1;
            end
            if (mutate && n == 50) io.start = 1'b1;
            if (mutate && n == 51) io.start = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag);
        int bad, first_bad;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        check({tag, "_plots"}, plot_n, 200);
        check({tag, "_first_plot"}, first_plot, 1);
        check({tag, "_last_plot"}, last_plot, 200);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_cycle"}, done_at, 201);
        check({tag, "_busy_vs_plot"}, busy_bad, 0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 200 && i < plot_n; i++) begin
            model(i, ex, ey, ec);
            if (cap_x[i] !== ex || cap_y[i] !== ey || cap_c[i] !== ec) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        check({tag, "_pixel_mismatches"}, bad, 0);
        if (first_bad >= 0) begin
            model(first_bad, ex, ey, ec);
            $display("  pixel %0d got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     first_bad, cap_x[first_bad], cap_y[first_bad],
                     cap_c[first_bad], ex, ey, ec);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pn, dn;
        bit have;
        vec_t prev;

        tbl[0]  = '{8'd10,  7'd20,  ZERO, ZERO,  0,   8'd10,  7'd20,  3'b000};
        tbl[1]  = '{8'd10,  7'd20,  ZERO, ZERO,  1,   8'd11,  7'd20,  3'b111};
        tbl[2]  = '{8'd10,  7'd20,  ZERO, ZERO,  160, 8'd34,  7'd20,  3'b000};
        tbl[3]  = '{8'd10,  7'd20,  ZERO, ZERO,  199, 8'd38,  7'd27,  3'b000};
        tbl[4]  = '{8'd10,  7'd20,  ZERO, SEVEN, 160, 8'd34,  7'd20,  3'b111};
        tbl[5]  = '{8'd10,  7'd20,  ZERO, SEVEN, 164, 8'd38,  7'd20,  3'b111};
        tbl[6]  = '{8'd10,  7'd20,  ZERO, SEVEN, 168, 8'd37,  7'd21,  3'b111};
        tbl[7]  = '{8'd10,  7'd20,  ZERO, SEVEN, 165, 8'd34,  7'd21,  3'b000};
        tbl[8]  = '{8'd250, 7'd125, ZERO, ZERO,  40,  8'd0,   7'd125, 3'b000};
        tbl[9]  = '{8'd250, 7'd125, ZERO, ZERO,  15,  8'd250, 7'd0,   3'b000};
        tbl[10] = '{8'd250, 7'd125, ZERO, ZERO,  41,  8'd1,   7'd125, 3'b111};

        io.start = 1'b0;
        m_ox = '0;
        m_oy = '0;
        for (int i = 0; i < 5; i++) m_g[i] = '0;
        drive_inputs();

        repeat (3) @(negedge clock);
        check("reset_x", io.x, 0);
        check("reset_y", io.y, 0);
        check("reset_colour", io.colour, 0);
        check("reset_plot", io.plot, 0);
        check("reset_busy", io.busy, 0);
        check("reset_done", io.done, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Table vectors: a new frame whenever the frame parameters change.
        have = 1'b0;
        for (int t = 0; t < 11; t++) begin
            if (!have || tbl[t].ox != prev.ox || tbl[t].oy != prev.oy ||
                tbl[t].g != prev.g || tbl[t].s1 != prev.s1) begin
                m_ox = tbl[t].ox;
                m_oy = tbl[t].oy;
                for (int i = 0; i < 4; i++) m_g[i] = tbl[t].g;
                m_g[4] = tbl[t].s1;
                run_frame(205, 1'b0);
                check_frame($sformatf("tbl%0d", t));
                have = 1'b1;
                prev = tbl[t];
            end
            check($sformatf("tbl%0d_x", t), cap_x[tbl[t].idx], tbl[t].ex);
            check($sformatf("tbl%0d_y", t), cap_y[tbl[t].idx], tbl[t].ey);
            check($sformatf("tbl%0d_colour", t), cap_c[tbl[t].idx], tbl[t].ec);
        end

        // Random frames against the model.
        for (int f = 0; f < 4; f++) begin
            m_ox = 8'($urandom);
            m_oy = 7'($urandom);
            for (int i = 0; i < 5; i++) m_g[i] = {8'($urandom), 32'($urandom)};
            run_frame(205, 1'b0);
            check_frame($sformatf("rand%0d", f));
        end

        // Inputs change and start pulses mid-frame: snapshot must hold.
        m_ox = 8'd40;
        m_oy = 7'd60;
        for (int i = 0; i < 5; i++) m_g[i] = {8'($urandom), 32'($urandom)};
        run_frame(240, 1'b1);
        check_frame("snapshot");

        // Back-to-back: start in the IDLE cycle right after done.
        m_ox = 8'd100;
        m_oy = 7'd5;
        for (int i = 0; i < 5; i++) m_g[i] = {8'($urandom), 32'($urandom)};
        run_frame(201, 1'b0);
        check_frame("b2b_first");
        m_ox = 8'd7;
        m_oy = 7'd90;
        run_frame(205, 1'b0);
        check_frame("b2b_second");

        // Asynchronous reset at pixel 100.
        @(negedge clock);
        drive_inputs();
        io.start = 1'b1;
        @(negedge clock);
        io.start = 1'b0;
        repeat (99) @(negedge clock);
        check("midreset_plot_before", io.plot, 1);
        #1 resetn = 1'b0;
        #1;
        check("midreset_plot", io.plot, 0);
        check("midreset_busy", io.busy, 0);
        check("midreset_done", io.done, 0);
        check("midreset_x", io.x, 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        pn = 0;
        dn = 0;
        for (int n = 0; n < 250; n++) begin
            @(negedge clock);
            if (io.plot) pn++;
            if (io.done) dn++;
        end
        check("postreset_plots", pn, 0);
        check("postreset_done", dn, 0);
        m_ox = 8'd200;
        m_oy = 7'd100;
        for (int i = 0; i < 5; i++) m_g[i] = {8'($urandom), 32'($urandom)};
        run_frame(205, 1'b0);
        check_frame("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
